if_seq_unit: RTL

- Sequential, parametrised successor to the combinational compare/branch datapath.
- Accepts one operand pair (A, B) per transaction over a valid/ready handshake and evaluates the three-stage compare-select chain below.
- The equal-operand divide runs on an iterative restoring divider; the result is returned over a valid/ready output port.
- Sits between operand producers and result consumers in PyXHDL-generated datapaths. WIDTH and the bias constants are parametrised.

---
 rtl/if_seq_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/if_seq_unit.sv
// if_seq_unit: sequential compare/branch datapath with an iterative restoring divider on the A==B path.
// Defining IF_SEQ_ACCUM_EN adds an output-handshake accumulator (ACC_CLR / ACC ports).
module if_seq_unit #(
  parameter int WIDTH     = 8,
  parameter int BIAS      = 1,
  parameter int FINAL_DEC = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] XOUT,
  output logic             DIV_ZERO
`ifdef IF_SEQ_ACCUM_EN
  ,
  input  logic             ACC_CLR,
  output logic [WIDTH-1:0] ACC
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] BIAS_W    = WIDTH'(BIAS);
  localparam logic [WIDTH-1:0] DEC_W     = WIDTH'(FINAL_DEC);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DIV  = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r, t_r, rem_r, xout_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r, out_valid_r, div_zero_r;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] rem_next_s;
  logic             q_bit_s;
  logic             eq_s;

  // Stages 1-3 for unequal operands; every step wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neq_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    if (a > b) begin
      t = a + a;
      t = t - a;
      t = t - DEC_W;
    end else begin
      t = a - b;
      t = t + a;
    end
    return t;
  endfunction

  // One restoring-divider step: t_r shifts out dividend bits and collects quotient bits.
  always_comb begin
    eq_s        = (a_r == b_r);
    rem_shift_s = {rem_r, t_r[WIDTH-1]};
    if (rem_shift_s >= {1'b0, a_r}) begin
      q_bit_s    = 1'b1;
      rem_next_s = rem_shift_s[WIDTH-1:0] - a_r;
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = rem_shift_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      t_r         <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      xout_r      <= '0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (IN_VALID) begin
            a_r        <= A;
            b_r        <= B;
            div_zero_r <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= CALC;
          end
        end
        CALC: begin
          if (eq_s) begin
            t_r     <= a_r * b_r;
            rem_r   <= '0;
            cnt_r   <= '0;
            state_r <= DIV;
          end else begin
            t_r     <= neq_result(a_r, b_r);
            state_r <= FIN;
          end
        end
        DIV: begin
          t_r   <= {t_r[WIDTH-2:0], q_bit_s};
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          // A zero divisor yields an all-ones quotient; the bias add still wraps.
          if (eq_s) begin
            xout_r     <= t_r + BIAS_W;
            div_zero_r <= (a_r == {WIDTH{1'b0}});
          end else begin
            xout_r     <= t_r;
          end
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign XOUT      = xout_r;
  assign DIV_ZERO  = div_zero_r;

`ifdef IF_SEQ_ACCUM_EN
  logic [WIDTH-1:0] acc_r;
  logic             handshake_s;

  assign handshake_s = (state_r == DONE) && OUT_READY;

  // Accumulates delivered results; clear wins over a coincident handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r <= '0;
    end else if (ACC_CLR) begin
      acc_r <= '0;
    end else if (handshake_s) begin
      acc_r <= acc_r + xout_r;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign ACC = acc_r;
`endif

endmodule
